// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - two-port round-robin arbiter and access sequencer for a single-port RAM
module ram_port_arbiter #(
    parameter int ADDR_WIDTH     = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rstn,

    input  logic                  a_req_valid,
    input  logic                  a_req_wr_rd,
    input  logic [ADDR_WIDTH-1:0] a_req_addr,
    input  logic [DATA_WIDTH-1:0] a_req_wdata,
    output logic                  a_req_ready,
    output logic                  a_rsp_valid,
    output logic [DATA_WIDTH-1:0] a_rsp_rdata,
    output logic                  a_rsp_error,

    input  logic                  b_req_valid,
    input  logic                  b_req_wr_rd,
    input  logic [ADDR_WIDTH-1:0] b_req_addr,
    input  logic [DATA_WIDTH-1:0] b_req_wdata,
    output logic                  b_req_ready,
    output logic                  b_rsp_valid,
    output logic [DATA_WIDTH-1:0] b_rsp_rdata,
    output logic                  b_rsp_error,

    output logic                  mem_en,
    output logic                  mem_wr_rd,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  mem_valid,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    input  logic                  mem_ready,
    input  logic                  mem_error
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    // last_grant_b: 1 when B owned the previous transaction (reset value so A wins the first tie)
    logic                    last_grant_b;
    // owner_b: 1 when the transaction in flight belongs to port B
    logic                    owner_b;
    logic                    txn_wr;
    logic [ADDR_WIDTH-1:0]   txn_addr;
    logic [DATA_WIDTH-1:0]   txn_wdata;
    logic [CNT_W-1:0]        busy_cnt;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q;
    logic                    rsp_error_q;

    logic                    pick_a;
    logic                    pick_b;
    logic                    accept;
    logic                    timeout_hit;

    // Round-robin choice: a lone requester always wins, a tie goes to the port that did not win last
    always_comb begin
        pick_a      = a_req_valid & (~b_req_valid | last_grant_b);
        pick_b      = b_req_valid & (~a_req_valid | ~last_grant_b);
        accept      = (state == ST_IDLE) & (pick_a | pick_b) & rstn;
        timeout_hit = (busy_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // Next-state and request handshake; ready is gated by rstn so nothing is accepted while reset is held
    always_comb begin
        state_nxt   = state;
        a_req_ready = 1'b0;
        b_req_ready = 1'b0;
        case (state)
            ST_IDLE: begin
                a_req_ready = pick_a & rstn;
                b_req_ready = pick_b & rstn;
                if (pick_a | pick_b) begin
                    state_nxt = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (mem_ready | timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register; reset aborts any transaction in flight immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Capture the granted request and remember who won for the next tie
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant_b <= 1'b1;
            owner_b      <= 1'b0;
            txn_wr       <= 1'b0;
            txn_addr     <= '0;
            txn_wdata    <= '0;
        end else if (accept) begin
            last_grant_b <= ~pick_a;
            owner_b      <= ~pick_a;
            txn_wr       <= pick_a ? a_req_wr_rd : b_req_wr_rd;
            txn_addr     <= pick_a ? a_req_addr  : b_req_addr;
            txn_wdata    <= pick_a ? a_req_wdata : b_req_wdata;
        end
    end

    // Watchdog counter counts BUSY cycles and clears whenever BUSY is left
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_cnt <= '0;
        end else if (state == ST_BUSY && !(mem_ready || timeout_hit)) begin
            busy_cnt <= busy_cnt + 1'b1;
        end else begin
            busy_cnt <= '0;
        end
    end

    // Latch the completion (or the forced timeout error) for the single response cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rsp_rdata_q <= '0;
            rsp_error_q <= 1'b0;
        end else if (state == ST_BUSY) begin
            if (mem_ready) begin
                rsp_rdata_q <= txn_wr ? '0 : mem_dout;
                rsp_error_q <= mem_error;
            end else if (timeout_hit) begin
                rsp_rdata_q <= '0;
                rsp_error_q <= 1'b1;
            end
        end
    end

    // RAM request bus is live only in BUSY and is zero otherwise
    always_comb begin
        mem_en    = (state == ST_BUSY);
        mem_valid = (state == ST_BUSY);
        mem_wr_rd = (state == ST_BUSY) & txn_wr;
        mem_addr  = (state == ST_BUSY) ? txn_addr  : '0;
        mem_din   = (state == ST_BUSY) ? txn_wdata : '0;
    end

    // Response is steered to the owning port; the other port sees zeros
    always_comb begin
        a_rsp_valid = (state == ST_RESP) & ~owner_b;
        b_rsp_valid = (state == ST_RESP) &  owner_b;
        a_rsp_rdata = a_rsp_valid ? rsp_rdata_q : '0;
        b_rsp_rdata = b_rsp_valid ? rsp_rdata_q : '0;
        a_rsp_error = a_rsp_valid & rsp_error_q;
        b_rsp_error = b_rsp_valid & rsp_error_q;
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - self-checking bench for ram_port_arbiter
module tb_ram_port_arbiter;

    localparam int AW = 8;
    localparam int DW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rstn;
    logic          a_req_valid, a_req_wr_rd, a_req_ready, a_rsp_valid, a_rsp_error;
    logic [AW-1:0] a_req_addr;
    logic [DW-1:0] a_req_wdata, a_rsp_rdata;
    logic          b_req_valid, b_req_wr_rd, b_req_ready, b_rsp_valid, b_rsp_error;
    logic [AW-1:0] b_req_addr;
    logic [DW-1:0] b_req_wdata, b_rsp_rdata;
    logic          mem_en, mem_wr_rd, mem_valid, mem_ready, mem_error;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_dout;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rstn(rstn),
        .a_req_valid(a_req_valid), .a_req_wr_rd(a_req_wr_rd), .a_req_addr(a_req_addr),
        .a_req_wdata(a_req_wdata), .a_req_ready(a_req_ready), .a_rsp_valid(a_rsp_valid),
        .a_rsp_rdata(a_rsp_rdata), .a_rsp_error(a_rsp_error),
        .b_req_valid(b_req_valid), .b_req_wr_rd(b_req_wr_rd), .b_req_addr(b_req_addr),
        .b_req_wdata(b_req_wdata), .b_req_ready(b_req_ready), .b_rsp_valid(b_rsp_valid),
        .b_rsp_rdata(b_rsp_rdata), .b_rsp_error(b_rsp_error),
        .mem_en(mem_en), .mem_wr_rd(mem_wr_rd), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_valid(mem_valid), .mem_dout(mem_dout), .mem_ready(mem_ready), .mem_error(mem_error)
    );

    function automatic logic [112:0] outs();
        return {a_req_ready, b_req_ready, a_rsp_valid, a_rsp_error, a_rsp_rdata,
                b_rsp_valid, b_rsp_error, b_rsp_rdata,
                mem_en, mem_valid, mem_wr_rd, mem_addr, mem_din};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_str(input string name, input string act, input string exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got '%s' expected '%s'", name, act, exp);
        end
    endtask

    // RAM stand-in: completes on the ram_lat-th BUSY cycle (0 = never), flags errors at 0xFF,
    // and drives noise on ready/error/dout whenever no request is present
    logic [DW-1:0] ram_mem [256];
    int            ram_lat   = 1;
    int            busy_seen = 0;
    always @(posedge clk) begin
        #1;
        if (mem_valid) begin
            busy_seen = busy_seen + 1;
            mem_ready = (ram_lat != 0) && (busy_seen == ram_lat);
            mem_error = mem_ready && (mem_addr == 8'hFF);
            mem_dout  = mem_wr_rd ? $urandom : ram_mem[mem_addr];
            if (mem_ready && mem_wr_rd) ram_mem[mem_addr] = mem_din;
        end else begin
            busy_seen = 0;
            mem_ready = 1'($urandom_range(0, 1));
            mem_error = 1'($urandom_range(0, 1));
            mem_dout  = $urandom;
        end
    end

    // Transaction-level reference: one request in flight, a response one cycle after completion,
    // ties resolved against the previous winner
    bit            m_busy = 0, m_resp = 0, m_port = 0, m_last = 1, m_wr = 0, m_rerr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [DW-1:0] m_data = '0, m_rdata = '0;
    int            m_elapsed = 0;

    string         grant_log = "";
    int            vcyc = 0;
    int            rsp_count = 0;
    logic [AW-1:0] obs_addr = '0;
    logic [DW-1:0] obs_din = '0;
    logic          obs_wr = 1'b0;

    // Every-cycle comparison against the reference, plus observation bookkeeping
    always @(negedge clk) begin
        logic          e_ar, e_br, e_av, e_ae, e_bv, e_be, e_en, e_wr;
        logic [DW-1:0] e_ad, e_bd, e_din;
        logic [AW-1:0] e_addr;
        logic [112:0]  e_vec;
        bit            win;
        e_ar = 0; e_br = 0; e_av = 0; e_ae = 0; e_bv = 0; e_be = 0; e_en = 0; e_wr = 0;
        e_ad = '0; e_bd = '0; e_din = '0; e_addr = '0;
        if (!rstn) begin
            m_busy = 0; m_resp = 0; m_last = 1; m_elapsed = 0;
        end else if (m_resp) begin
            if (m_port) begin e_bv = 1; e_bd = m_rdata; e_be = m_rerr; end
            else        begin e_av = 1; e_ad = m_rdata; e_ae = m_rerr; end
            m_resp = 0;
        end else if (m_busy) begin
            e_en = 1; e_wr = m_wr; e_addr = m_addr; e_din = m_data;
            m_elapsed++;
            if (mem_ready) begin
                m_rdata = m_wr ? '0 : mem_dout; m_rerr = mem_error; m_busy = 0; m_resp = 1;
            end else if (m_elapsed == TO) begin
                m_rdata = '0; m_rerr = 1; m_busy = 0; m_resp = 1;
            end
        end else if (a_req_valid || b_req_valid) begin
            win = (a_req_valid && b_req_valid) ? !m_last : b_req_valid;
            if (win) begin e_br = 1; m_wr = b_req_wr_rd; m_addr = b_req_addr; m_data = b_req_wdata; end
            else     begin e_ar = 1; m_wr = a_req_wr_rd; m_addr = a_req_addr; m_data = a_req_wdata; end
            m_port = win; m_last = win; m_busy = 1; m_elapsed = 0;
        end
        e_vec = {e_ar, e_br, e_av, e_ae, e_ad, e_bv, e_be, e_bd, e_en, e_en, e_wr, e_addr, e_din};
        checks++;
        if (outs() !== e_vec) begin
            errors++;
            $display("FAIL cycle_compare @%0t: got %029h expected %029h", $time, outs(), e_vec);
        end
        if (a_req_ready) grant_log = {grant_log, "A"};
        if (b_req_ready) grant_log = {grant_log, "B"};
        if (a_req_ready || b_req_ready) vcyc = 0;
        if (mem_valid) begin
            vcyc++; obs_addr = mem_addr; obs_din = mem_din; obs_wr = mem_wr_rd;
        end
        if (a_rsp_valid || b_rsp_valid) rsp_count++;
    end

    task automatic issue(input bit port, input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] data);
        int n = 0;
        if (port) begin b_req_valid = 1; b_req_wr_rd = wr; b_req_addr = addr; b_req_wdata = data; end
        else      begin a_req_valid = 1; a_req_wr_rd = wr; a_req_addr = addr; a_req_wdata = data; end
        do begin
            @(negedge clk);
            n++;
        end while (!(port ? b_req_ready : a_req_ready) && n < 200);
        chk("issue_accepted", 128'(n < 200), 128'(1));
        @(posedge clk);
        #1;
        if (port) b_req_valid = 0;
        else      a_req_valid = 0;
    endtask

    task automatic wait_rsp(input bit port, output logic [DW-1:0] rd, output logic er);
        int n = 0;
        rd = '0;
        er = 1'b0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (port ? b_rsp_valid : a_rsp_valid) begin
                rd = port ? b_rsp_rdata : a_rsp_rdata;
                er = port ? b_rsp_error : a_rsp_error;
                break;
            end
        end
        chk("rsp_seen", 128'(n < 200), 128'(1));
    endtask

    initial begin
        logic [DW-1:0] rd, rd2;
        logic          er, er2;
        int            va, rc0;
        for (int i = 0; i < 256; i++) ram_mem[i] = '0;
        rstn = 0;
        a_req_valid = 0; a_req_wr_rd = 0; a_req_addr = '0; a_req_wdata = '0;
        b_req_valid = 0; b_req_wr_rd = 0; b_req_addr = '0; b_req_wdata = '0;
        mem_ready = 0; mem_error = 0; mem_dout = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 128'(outs()), 128'(0));
        rstn = 1;
        @(posedge clk);
        #1;

        // A write, one-cycle RAM
        ram_lat = 1;
        issue(0, 1, 8'h10, 32'hDEADBEEF);
        wait_rsp(0, rd, er);
        chk("a_wr_error", 128'(er), 128'(0));
        chk("a_wr_rdata", 128'(rd), 128'(0));
        chk("a_wr_valid_cycles", 128'(vcyc), 128'(1));
        chk("a_wr_mem_addr", 128'(obs_addr), 128'h10);
        chk("a_wr_mem_din", 128'(obs_din), 128'hDEADBEEF);
        chk("a_wr_mem_wr", 128'(obs_wr), 128'(1));

        // B read of the same address, three-cycle RAM
        ram_lat = 3;
        issue(1, 0, 8'h10, 32'h0);
        wait_rsp(1, rd, er);
        chk("b_rd_rdata", 128'(rd), 128'hDEADBEEF);
        chk("b_rd_error", 128'(er), 128'(0));
        chk("b_rd_valid_cycles", 128'(vcyc), 128'(3));

        // Both ports continuously valid after reset
        @(posedge clk); #1; rstn = 0;
        @(posedge clk); #1; rstn = 1;
        grant_log = "";
        ram_lat = 2;
        fork
            begin issue(0, 1, 8'h01, 32'h11111111); issue(0, 1, 8'h02, 32'h22222222); end
            begin issue(1, 1, 8'h03, 32'h33333333); issue(1, 1, 8'h04, 32'h44444444); end
        join
        repeat (6) @(posedge clk);
        #1;
        chk_str("fair_order", grant_log, "ABAB");

        // Timeout on A, B waiting behind it
        ram_lat = 0;
        grant_log = "";
        va = 0;
        fork
            begin
                issue(0, 0, 8'h20, 32'h0);
                wait_rsp(0, rd, er);
                va = vcyc;
                ram_lat = 1;
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                issue(1, 1, 8'h21, 32'hCAFEF00D);
                wait_rsp(1, rd2, er2);
            end
        join
        chk("timeout_error", 128'(er), 128'(1));
        chk("timeout_rdata", 128'(rd), 128'(0));
        chk("timeout_busy_cycles", 128'(va), 128'(TO));
        chk("after_timeout_b_error", 128'(er2), 128'(0));
        chk_str("timeout_order", grant_log, "AB");

        // RAM error on B read of 0xFF
        ram_lat = 2;
        issue(1, 0, 8'hFF, 32'h0);
        wait_rsp(1, rd, er);
        chk("mem_error_b", 128'(er), 128'(1));

        // Reset while BUSY
        ram_lat = 0;
        issue(0, 1, 8'h30, 32'h12345678);
        repeat (3) @(posedge clk);
        #2;
        chk("busy_before_reset", 128'(mem_valid), 128'(1));
        rstn = 0;
        #1;
        chk("async_reset_outputs", 128'(outs()), 128'(0));
        rc0 = rsp_count;
        grant_log = "";
        ram_lat = 1;
        a_req_valid = 1; b_req_valid = 1;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1;
        fork
            issue(0, 0, 8'h10, 32'h0);
            issue(1, 0, 8'h21, 32'h0);
        join
        repeat (6) @(posedge clk);
        #1;
        chk_str("post_reset_order", grant_log, "AB");
        chk("post_reset_rsp_count", 128'(rsp_count - rc0), 128'(2));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
